// File: rtl/led_matrix_scanner_pkg.sv
// Shared constants and bank-select encoding for the LED matrix scanner slice.
package matrix_pkg;

   localparam int MATRIX_COLS = 8;
   localparam int MATRIX_ROWS = 16;
   localparam int SCAN_DIV    = 10000;

   typedef enum logic {
      BANK_A = 1'b0,
      BANK_B = 1'b1
   } bank_e;

   function automatic bank_e other_bank(input bank_e b);
      return (b == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Row-write bus and bank-swap handshake between game logic and the scanner.
interface led_matrix_scanner_if
   import matrix_pkg::*;
#(
   parameter int COLS = MATRIX_COLS,
   parameter int ROWS = MATRIX_ROWS
);

   localparam int YW = $clog2(ROWS);

   logic            wrEn;
   logic [YW-1:0]   wrRow;
   logic [COLS-1:0] wrData;
   logic            swapReq;
   logic            swapAck;

   modport master (
      output wrEn,
      output wrRow,
      output wrData,
      output swapReq,
      input  swapAck
   );

   modport slave (
      input  wrEn,
      input  wrRow,
      input  wrData,
      input  swapReq,
      output swapAck
   );

endinterface

// File: rtl/led_matrix_scanner_prescaler.sv
// Free-running divider: tick is high for the one cycle where the count is DIV-1.
module tick_prescaler
   import matrix_pkg::*;
#(
   parameter int DIV = SCAN_DIV
) (
   input  logic CLK,
   input  logic RSTn,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED dot-matrix scan driver: scans the front bank one pixel per
// tick while rows are written into the back bank; banks swap on frame end.
module led_matrix_scanner
   import matrix_pkg::*;
#(
   parameter int COLS = MATRIX_COLS,
   parameter int ROWS = MATRIX_ROWS,
   parameter int DIV  = SCAN_DIV,
   parameter int XW   = $clog2(COLS),
   parameter int YW   = $clog2(ROWS)
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   led_matrix_scanner_if.slave   bus,
   input  logic                  blank,
   output logic [XW-1:0]         xOut,
   output logic [YW-1:0]         yOut,
   output logic                  pixOn,
   output logic                  frameDone
);

   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_TOP  = YW'(ROWS - 1);
   localparam logic [YW:0]   ROWS_L = (YW + 1)'(ROWS);

   logic            tick;
   logic            frame_end;
   logic            swap;
   logic            row_ok;
   bank_e           front;
   logic [COLS-1:0] bank [2][ROWS];

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .CLK  (CLK),
      .RSTn (RSTn),
      .tick (tick)
   );

   assign frame_end = tick && (xOut == X_LAST) && (yOut == '0);
   assign swap      = frame_end && bus.swapReq;
   assign row_ok    = ({1'b0, bus.wrRow} < ROWS_L);
   assign pixOn     = !blank && bank[front][yOut][xOut];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         xOut        <= '0;
         yOut        <= Y_TOP;
         front       <= BANK_A;
         frameDone   <= 1'b0;
         bus.swapAck <= 1'b0;
      end else begin
         frameDone   <= frame_end;
         bus.swapAck <= swap;
         if (swap) begin
            front <= other_bank(front);
         end
         if (tick) begin
            if (xOut == X_LAST) begin
               xOut <= '0;
               yOut <= (yOut == '0) ? Y_TOP : yOut - 1'b1;
            end else begin
               xOut <= xOut + 1'b1;
            end
         end
      end
   end

   // Write target uses the pre-edge front, so a write in the swap cycle lands
   // in the bank that is about to become visible.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
               bank[b][r] <= '0;
            end
         end
      end else if (bus.wrEn && row_ok) begin
         bank[other_bank(front)][bus.wrRow] <= bus.wrData;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: default, DIV=4, DIV=2 and a 3x5 DIV=1 build.
module tb_led_matrix_scanner;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic blank = 1'b0;
   int   t;
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   // Posedges since reset release; the scan model is a pure function of it.
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) t <= 0;
      else       t <= t + 1;
   end

   function automatic int mx(input int tt, input int div, input int cols, input int rows);
      int idx;
      idx = (tt / div) % (cols * rows);
      return idx % cols;
   endfunction

   function automatic int my(input int tt, input int div, input int cols, input int rows);
      int idx;
      idx = (tt / div) % (cols * rows);
      return rows - 1 - idx / cols;
   endfunction

   led_matrix_scanner_if #(.COLS(8), .ROWS(16)) bd ();
   led_matrix_scanner_if #(.COLS(8), .ROWS(16)) b4 ();
   led_matrix_scanner_if #(.COLS(8), .ROWS(16)) b2 ();
   led_matrix_scanner_if #(.COLS(3), .ROWS(5))  bo ();

   logic [2:0] xd, x4, x2;
   logic [3:0] yd, y4, y2;
   logic       pd, p4, p2, fd, f4, f2;
   logic [1:0] xo;
   logic [2:0] yo;
   logic       po, fo;

   led_matrix_scanner dut_def (
      .CLK(CLK), .RSTn(RSTn), .bus(bd.slave), .blank(blank),
      .xOut(xd), .yOut(yd), .pixOn(pd), .frameDone(fd)
   );

   led_matrix_scanner #(.COLS(8), .ROWS(16), .DIV(4)) dut4 (
      .CLK(CLK), .RSTn(RSTn), .bus(b4.slave), .blank(blank),
      .xOut(x4), .yOut(y4), .pixOn(p4), .frameDone(f4)
   );

   led_matrix_scanner #(.COLS(8), .ROWS(16), .DIV(2)) dut2 (
      .CLK(CLK), .RSTn(RSTn), .bus(b2.slave), .blank(blank),
      .xOut(x2), .yOut(y2), .pixOn(p2), .frameDone(f2)
   );

   led_matrix_scanner #(.COLS(3), .ROWS(5), .DIV(1)) dut_odd (
      .CLK(CLK), .RSTn(RSTn), .bus(bo.slave), .blank(blank),
      .xOut(xo), .yOut(yo), .pixOn(po), .frameDone(fo)
   );

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      repeat (2) @(negedge CLK);
      checks++; if (xd !== 3'd0)  begin failures++; $display("FAIL rst_x got=%0d exp=0", xd); end
      checks++; if (yd !== 4'd15) begin failures++; $display("FAIL rst_y got=%0d exp=15", yd); end
      checks++; if (pd !== 1'b0)  begin failures++; $display("FAIL rst_pix got=%0b exp=0", pd); end
      checks++; if (fd !== 1'b0)  begin failures++; $display("FAIL rst_frameDone got=%0b exp=0", fd); end
      checks++; if (bd.swapAck !== 1'b0) begin failures++; $display("FAIL rst_swapAck got=%0b exp=0", bd.swapAck); end
      RSTn = 1'b1;
      while (t < 9999) @(negedge CLK);
      checks++; if (xd !== 3'd0 || yd !== 4'd15) begin failures++; $display("FAIL div_hold x=%0d y=%0d exp x=0 y=15", xd, yd); end
      @(negedge CLK);
      checks++; if (xd !== 3'd1) begin failures++; $display("FAIL first_tick x=%0d exp=1", xd); end
   endtask

   task automatic test_scan();
      int errs = 0;
      int pulses = 0;
      int pulse_t = -1;
      do_reset();
      while (t <= 520) begin
         if (x4 !== mx(t, 4, 8, 16) || y4 !== my(t, 4, 8, 16)) errs++;
         if (f4) begin pulses++; pulse_t = t; end
         if (t == 32) begin
            checks++; if (x4 !== 3'd0 || y4 !== 4'd14) begin failures++; $display("FAIL row_wrap x=%0d y=%0d exp x=0 y=14", x4, y4); end
         end
         if (t == 512) begin
            checks++; if (x4 !== 3'd0 || y4 !== 4'd15) begin failures++; $display("FAIL frame_wrap x=%0d y=%0d exp x=0 y=15", x4, y4); end
         end
         @(negedge CLK);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL scan_order bad_samples=%0d exp=0", errs); end
      checks++; if (pulses != 1 || pulse_t != 512) begin failures++; $display("FAIL frameDone_div4 pulses=%0d at=%0d exp 1 at 512", pulses, pulse_t); end
   endtask

   task automatic test_swap();
      int early = 0;
      int errs = 0;
      int acks = 0;
      bit pe;
      do_reset();
      b2.wrEn = 1'b1; b2.wrRow = 4'd15; b2.wrData = 8'b0000_0101; b2.swapReq = 1'b1;
      @(negedge CLK);
      b2.wrEn = 1'b0;
      while (t < 256) begin
         if (b2.swapAck || f2) early++;
         @(negedge CLK);
      end
      checks++; if (early != 0) begin failures++; $display("FAIL early_pulse count=%0d exp=0", early); end
      checks++; if (b2.swapAck !== 1'b1 || f2 !== 1'b1) begin failures++; $display("FAIL swap_at_256 ack=%0b done=%0b exp 1 1", b2.swapAck, f2); end
      b2.swapReq = 1'b0;
      while (t <= 511) begin
         pe = (my(t, 2, 8, 16) == 15) && (mx(t, 2, 8, 16) == 0 || mx(t, 2, 8, 16) == 2);
         if (x2 !== mx(t, 2, 8, 16) || y2 !== my(t, 2, 8, 16) || p2 !== pe) errs++;
         if (t > 256 && b2.swapAck) acks++;
         @(negedge CLK);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL row15_pattern bad_samples=%0d exp=0", errs); end
      checks++; if (acks != 0 || b2.swapAck !== 1'b0 || f2 !== 1'b1) begin failures++; $display("FAIL no_reswap acks=%0d ack=%0b done=%0b exp 0 0 1", acks, b2.swapAck, f2); end
   endtask

   task automatic test_swap_write();
      int errs = 0;
      while (t < 767) @(negedge CLK);
      b2.wrEn = 1'b1; b2.wrRow = 4'd3; b2.wrData = 8'hFF; b2.swapReq = 1'b1;
      @(negedge CLK);
      checks++; if (b2.swapAck !== 1'b1) begin failures++; $display("FAIL swap_write_ack got=%0b exp=1", b2.swapAck); end
      b2.wrEn = 1'b0; b2.swapReq = 1'b0;
      while (t <= 1023) begin
         if (p2 !== (my(t, 2, 8, 16) == 3)) errs++;
         @(negedge CLK);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL row3_in_swap_cycle bad_samples=%0d exp=0", errs); end
   endtask

   task automatic test_blank();
      int lit = 0;
      int derr = 0;
      while (t < 1024) @(negedge CLK);
      for (int r = 0; r < 16; r++) begin
         b2.wrEn = 1'b1; b2.wrRow = 4'(r); b2.wrData = 8'hFF;
         @(negedge CLK);
      end
      b2.wrEn = 1'b0; b2.swapReq = 1'b1; blank = 1'b1;
      while (t <= 1535) begin
         if (p2 !== 1'b0) lit++;
         if (f2 !== (t % 256 == 0)) derr++;
         if (t == 1280) begin
            checks++; if (b2.swapAck !== 1'b1) begin failures++; $display("FAIL blank_swap_ack got=%0b exp=1", b2.swapAck); end
            b2.swapReq = 1'b0;
         end
         @(negedge CLK);
      end
      checks++; if (lit != 0) begin failures++; $display("FAIL blank_forces_off lit_samples=%0d exp=0", lit); end
      checks++; if (derr != 0) begin failures++; $display("FAIL blank_frame_timing bad_samples=%0d exp=0", derr); end
      while (t < 1540) @(negedge CLK);
      blank = 1'b0;
      #1;
      checks++; if (p2 !== 1'b1) begin failures++; $display("FAIL unblank_immediate got=%0b exp=1", p2); end
      checks++; if (x2 !== mx(t, 2, 8, 16) || y2 !== my(t, 2, 8, 16)) begin failures++; $display("FAIL unblank_coords x=%0d y=%0d", x2, y2); end
   endtask

   task automatic test_reset_mid();
      int errs = 0;
      int acks = 0;
      b2.swapReq = 1'b1;
      while (t < 1600) @(negedge CLK);
      RSTn = 1'b0;
      #1;
      checks++; if (x2 !== 3'd0 || y2 !== 4'd15) begin failures++; $display("FAIL mid_rst_xy x=%0d y=%0d exp x=0 y=15", x2, y2); end
      checks++; if (p2 !== 1'b0 || f2 !== 1'b0 || b2.swapAck !== 1'b0) begin failures++; $display("FAIL mid_rst_outs pix=%0b done=%0b ack=%0b exp 0 0 0", p2, f2, b2.swapAck); end
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      while (t < 256) begin
         if (p2 !== 1'b0 || x2 !== mx(t, 2, 8, 16) || y2 !== my(t, 2, 8, 16)) errs++;
         if (b2.swapAck) acks++;
         @(negedge CLK);
      end
      checks++; if (errs != 0 || acks != 0) begin failures++; $display("FAIL bank_a_cleared bad=%0d acks=%0d exp 0 0", errs, acks); end
      checks++; if (b2.swapAck !== 1'b1) begin failures++; $display("FAIL post_rst_swap ack=%0b exp=1", b2.swapAck); end
      b2.swapReq = 1'b0;
      errs = 0;
      while (t <= 511) begin
         if (p2 !== 1'b0) errs++;
         @(negedge CLK);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL bank_b_cleared lit_samples=%0d exp=0", errs); end
   endtask

   task automatic test_odd();
      int errs = 0;
      int aerr = 0;
      bit pe;
      do_reset();
      bo.wrEn = 1'b1; bo.wrRow = 3'd5; bo.wrData = 3'b111;
      @(negedge CLK);
      bo.wrRow = 3'd6;
      @(negedge CLK);
      bo.wrRow = 3'd7;
      @(negedge CLK);
      bo.wrRow = 3'd4; bo.wrData = 3'b010;
      @(negedge CLK);
      bo.wrEn = 1'b0; bo.swapReq = 1'b1;
      while (t <= 29) begin
         pe = (t >= 15) && (my(t, 1, 3, 5) == 4) && (mx(t, 1, 3, 5) == 1);
         if (xo !== mx(t, 1, 3, 5) || yo !== my(t, 1, 3, 5) || po !== pe) errs++;
         if (bo.swapAck !== (t == 15)) aerr++;
         if (t == 15) bo.swapReq = 1'b0;
         @(negedge CLK);
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL odd_scan_pixels bad_samples=%0d exp=0", errs); end
      checks++; if (aerr != 0) begin failures++; $display("FAIL odd_swap_ack bad_samples=%0d exp=0", aerr); end
   endtask

   initial begin
      bd.wrEn = 1'b0; bd.wrRow = '0; bd.wrData = '0; bd.swapReq = 1'b0;
      b4.wrEn = 1'b0; b4.wrRow = '0; b4.wrData = '0; b4.swapReq = 1'b0;
      b2.wrEn = 1'b0; b2.wrRow = '0; b2.wrData = '0; b2.swapReq = 1'b0;
      bo.wrEn = 1'b0; bo.wrRow = '0; bo.wrData = '0; bo.swapReq = 1'b0;
      test_reset();
      test_scan();
      test_swap();
      test_swap_write();
      test_blank();
      test_reset_mid();
      test_odd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
